// File: rtl/mesm6_timer_pkg.sv
// Shared definitions for the multi-channel MESM-6 timer: bus geometry,
// per-channel register offsets, STAT bit positions and the counting mode.
package mesm6_timer_pkg;

    localparam int BUS_AW = 15;
    localparam int BUS_DW = 48;

    // Register offsets inside one channel's 8-word window
    localparam logic [2:0] TIM_CNT  = 3'd0;
    localparam logic [2:0] TIM_STAT = 3'd1;
    localparam logic [2:0] TIM_MODE = 3'd2;
    localparam logic [2:0] TIM_RSVD = 3'd3;
    localparam logic [2:0] TIM_IEN  = 3'd4;
    localparam logic [2:0] TIM_EN   = 3'd5;
    localparam logic [2:0] TIM_PRD  = 3'd6;
    localparam logic [2:0] TIM_PRS  = 3'd7;

    // STAT register bit positions
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_EN_BIT   = 1;

    typedef enum logic {
        TIM_ONESHOT = 1'b0,
        TIM_RELOAD  = 1'b1
    } tim_mode_t;

endpackage

// File: rtl/mesm6_timer_chan.sv
// One timer channel: register file, free-running prescaler, down-counter
// and sticky pending flag. Read data is combinational; the top registers it.
module mesm6_timer_chan
    import mesm6_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRS_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        reg_sel,
    input  logic [BUS_DW-1:0] wdata,
    output logic [BUS_DW-1:0] rd_data,
    output logic              irq
);

    localparam int PCNT_W = (1 << PRS_W) - 1;

    logic [CNT_W-1:0]  cnt_reg,  cnt_next;
    logic [CNT_W-1:0]  prd_reg,  prd_next;
    logic [PRS_W-1:0]  prs_reg,  prs_next;
    logic [PCNT_W-1:0] pcnt_reg, pcnt_next;
    tim_mode_t         mode_reg, mode_next;
    logic              en_reg,   en_next;
    logic              ien_reg,  ien_next;
    logic              pend_reg, pend_next;

    logic [PCNT_W-1:0] prs_mask;
    logic              tick;
    logic              expire;
    logic              wdata_unused;

    // Only the low field bits of a write are meaningful; the rest are dropped
    assign wdata_unused = ^wdata;

    // Mask of the low PRS bits of the prescaler counter
    generate
        for (genvar gi = 0; gi < PCNT_W; gi++) begin : g_mask
            assign prs_mask[gi] = (PRS_W'(gi) < prs_reg);
        end
    endgenerate

    assign tick   = ((pcnt_reg & prs_mask) == '0);
    assign expire = en_reg && tick && (cnt_reg == '0);
    assign irq    = pend_reg & ien_reg;

    // Next-state: counting first, then bus writes override (except PEND set)
    always_comb begin
        cnt_next  = cnt_reg;
        prd_next  = prd_reg;
        prs_next  = prs_reg;
        pcnt_next = pcnt_reg;
        mode_next = mode_reg;
        en_next   = en_reg;
        ien_next  = ien_reg;
        pend_next = pend_reg;

        if (en_reg) begin
            pcnt_next = pcnt_reg + PCNT_W'(1);
            if (tick) begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (mode_reg == TIM_RELOAD) begin
                    cnt_next = prd_reg;
                end else begin
                    en_next = 1'b0;
                end
            end
        end

        // Expiry beats a simultaneous software clear
        if (expire) begin
            pend_next = 1'b1;
        end else if (wr_en && reg_sel == TIM_STAT && wdata[STAT_PEND_BIT]) begin
            pend_next = 1'b0;
        end

        if (wr_en) begin
            case (reg_sel)
                TIM_MODE: mode_next = tim_mode_t'(wdata[0]);
                TIM_IEN:  ien_next  = wdata[0];
                TIM_EN: begin
                    en_next   = wdata[0];
                    cnt_next  = prd_reg;
                    pcnt_next = '0;
                end
                TIM_PRD:  prd_next  = wdata[CNT_W-1:0];
                TIM_PRS: begin
                    prs_next  = wdata[PRS_W-1:0];
                    pcnt_next = '0;
                end
                default: ;
            endcase
        end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            prd_reg  <= '0;
            prs_reg  <= '0;
            pcnt_reg <= '0;
            mode_reg <= TIM_ONESHOT;
            en_reg   <= 1'b0;
            ien_reg  <= 1'b0;
            pend_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            prd_reg  <= prd_next;
            prs_reg  <= prs_next;
            pcnt_reg <= pcnt_next;
            mode_reg <= mode_next;
            en_reg   <= en_next;
            ien_reg  <= ien_next;
            pend_reg <= pend_next;
        end
    end

    // Register read mux, zero-extended to the bus width
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            TIM_CNT: rd_data = BUS_DW'(cnt_reg);
            TIM_STAT: begin
                rd_data[STAT_PEND_BIT] = pend_reg;
                rd_data[STAT_EN_BIT]   = en_reg;
            end
            TIM_MODE: rd_data[0] = mode_reg;
            TIM_IEN:  rd_data[0] = ien_reg;
            TIM_EN:   rd_data[0] = en_reg;
            TIM_PRD:  rd_data = BUS_DW'(prd_reg);
            TIM_PRS:  rd_data = BUS_DW'(prs_reg);
            default:  rd_data = '0;
        endcase
    end

endmodule

// File: rtl/mesm6_timer_array.sv
// NCH-channel timer array on the 15-bit/48-bit peripheral bus: address
// decode, registered read data, access acknowledge and interrupt combine.
module mesm6_timer_array
    import mesm6_timer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 32,
    parameter int PRS_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BUS_AW-1:0] tim_addr,
    input  logic              tim_read,
    input  logic              tim_write,
    input  logic [BUS_DW-1:0] tim_wdata,
    output logic [BUS_DW-1:0] tim_rdata,
    output logic              tim_done,
    output logic              interrupt,
    output logic [NCH-1:0]    irq_vec
);

    logic [2:0]        addr_chan;
    logic [2:0]        addr_reg;
    logic              addr_unused;
    logic [BUS_DW-1:0] chan_rdata [NCH];
    logic [BUS_DW-1:0] rd_mux;

    assign addr_chan = tim_addr[5:3];
    assign addr_reg  = tim_addr[2:0];
    // Upper address bits select this block on the shared bus, decoded outside
    assign addr_unused = ^tim_addr[BUS_AW-1:6];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            mesm6_timer_chan #(
                .CNT_W (CNT_W),
                .PRS_W (PRS_W)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (tim_write && (addr_chan == 3'(gi))),
                .reg_sel (addr_reg),
                .wdata   (tim_wdata),
                .rd_data (chan_rdata[gi]),
                .irq     (irq_vec[gi])
            );
        end
    endgenerate

    assign interrupt = |irq_vec;

    // Channel select for reads; unpopulated channels read as zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (addr_chan == 3'(i)) begin
                rd_mux = chan_rdata[i];
            end
        end
    end

    // Bus response: one-cycle acknowledge, read data held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            tim_done  <= 1'b0;
            tim_rdata <= '0;
        end else begin
            tim_done <= tim_read | tim_write;
            if (tim_read) begin
                tim_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_mesm6_timer_array.sv
// Directed bench for mesm6_timer_array: one-shot, auto-reload, collisions,
// channel isolation, bus decode and reset behaviour.
module tb_mesm6_timer_array;

    localparam int NCH = 4;

    localparam int R_CNT  = 0;
    localparam int R_STAT = 1;
    localparam int R_MODE = 2;
    localparam int R_RSVD = 3;
    localparam int R_IEN  = 4;
    localparam int R_EN   = 5;
    localparam int R_PRD  = 6;
    localparam int R_PRS  = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] tim_addr = '0;
    logic        tim_read = 1'b0;
    logic        tim_write = 1'b0;
    logic [47:0] tim_wdata = '0;
    logic [47:0] tim_rdata;
    logic        tim_done;
    logic        interrupt;
    logic [3:0]  irq_vec;

    int checks = 0;
    int errors = 0;

    mesm6_timer_array #(
        .NCH   (NCH),
        .CNT_W (32),
        .PRS_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tim_addr  (tim_addr),
        .tim_read  (tim_read),
        .tim_write (tim_write),
        .tim_wdata (tim_wdata),
        .tim_rdata (tim_rdata),
        .tim_done  (tim_done),
        .interrupt (interrupt),
        .irq_vec   (irq_vec)
    );

    always #5 clk = ~clk;

    // All bus tasks start and end on a falling edge; each takes one cycle
    task automatic bus_write(input int ch, input int rg, input logic [47:0] d);
        tim_addr  = 15'((ch << 3) | rg);
        tim_wdata = d;
        tim_write = 1'b1;
        @(negedge clk);
        tim_write = 1'b0;
        $display("wr ch=%0d reg=%0d data=%0h", ch, rg, d);
    endtask

    task automatic bus_read(input int ch, input int rg, output logic [47:0] d, output logic done);
        tim_addr = 15'((ch << 3) | rg);
        tim_read = 1'b1;
        @(negedge clk);
        tim_read = 1'b0;
        d    = tim_rdata;
        done = tim_done;
        $display("rd ch=%0d reg=%0d data=%0h done=%0b", ch, rg, d, done);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [47:0] d;
        logic        dn;
        checks++;
        if (tim_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %0b expected 0", tim_done);
        end
        checks++;
        if (tim_rdata !== 48'h0) begin
            errors++; $display("FAIL reset_rdata: got %0h expected 0", tim_rdata);
        end
        checks++;
        if (interrupt !== 1'b0 || irq_vec !== 4'b0000) begin
            errors++; $display("FAIL reset_irq: got %0b/%b expected 0/0000", interrupt, irq_vec);
        end
        bus_read(0, R_PRD, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL reset_prd: got %0h expected 0", d);
        end
        bus_read(0, R_CNT, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL reset_cnt: got %0h expected 0", d);
        end
    endtask

    task automatic test_oneshot();
        logic [47:0] d;
        logic        dn;
        bus_write(0, R_PRS, 48'd0);
        bus_write(0, R_PRD, 48'd5);
        bus_write(0, R_IEN, 48'd1);
        bus_write(0, R_EN, 48'd1);
        for (int k = 0; k < 6; k++) begin
            bus_read(0, R_CNT, d, dn);
            checks++;
            if (d !== 48'(5 - k)) begin
                errors++; $display("FAIL oneshot_cnt%0d: got %0d expected %0d", k, d, 5 - k);
            end
            checks++;
            if (interrupt !== (k == 5)) begin
                errors++; $display("FAIL oneshot_irq%0d: got %0b expected %0b", k, interrupt, (k == 5));
            end
        end
        checks++;
        if (irq_vec !== 4'b0001) begin
            errors++; $display("FAIL oneshot_vec: got %b expected 0001", irq_vec);
        end
        bus_read(0, R_STAT, d, dn);
        checks++;
        if (d !== 48'h1) begin
            errors++; $display("FAIL oneshot_stat: got %0h expected 1", d);
        end
        bus_read(0, R_EN, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL oneshot_en: got %0h expected 0", d);
        end
        idle(5);
        checks++;
        if (interrupt !== 1'b1) begin
            errors++; $display("FAIL oneshot_level: got %0b expected 1", interrupt);
        end
        bus_write(0, R_STAT, 48'h1);
        checks++;
        if (interrupt !== 1'b0) begin
            errors++; $display("FAIL oneshot_clear: got %0b expected 0", interrupt);
        end
        bus_read(0, R_CNT, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL oneshot_cnt_end: got %0h expected 0", d);
        end
    endtask

    // ch2 expiries land on edges 13, 29, 45, 61, 77 after the EN write (edge 0)
    task automatic test_autoreload();
        logic [47:0] d;
        logic        dn;
        bus_write(2, R_MODE, 48'd1);
        bus_write(2, R_PRS, 48'd2);
        bus_write(2, R_PRD, 48'd3);
        bus_write(2, R_IEN, 48'd1);
        bus_write(2, R_EN, 48'd1);
        idle(12);
        checks++;
        if (irq_vec !== 4'b0000) begin
            errors++; $display("FAIL reload_early: got %b expected 0000", irq_vec);
        end
        idle(1);
        checks++;
        if (irq_vec !== 4'b0100) begin
            errors++; $display("FAIL reload_first: got %b expected 0100", irq_vec);
        end
        bus_read(2, R_CNT, d, dn);
        checks++;
        if (d !== 48'd3) begin
            errors++; $display("FAIL reload_cnt: got %0d expected 3", d);
        end
        idle(31);
        checks++;
        if (irq_vec !== 4'b0100 || interrupt !== 1'b1) begin
            errors++; $display("FAIL reload_third: got %b/%0b expected 0100/1", irq_vec, interrupt);
        end
        bus_read(2, R_STAT, d, dn);
        checks++;
        if (d !== 48'h3) begin
            errors++; $display("FAIL reload_stat: got %0h expected 3", d);
        end
    endtask

    task automatic test_collision();
        logic [47:0] d;
        logic        dn;
        bus_write(2, R_STAT, 48'h1);
        checks++;
        if (irq_vec !== 4'b0000) begin
            errors++; $display("FAIL coll_pre_clear: got %b expected 0000", irq_vec);
        end
        idle(13);
        bus_write(2, R_STAT, 48'h1);
        checks++;
        if (irq_vec !== 4'b0100) begin
            errors++; $display("FAIL coll_set_wins: got %b expected 0100", irq_vec);
        end
        bus_write(2, R_STAT, 48'h1);
        checks++;
        if (irq_vec !== 4'b0000) begin
            errors++; $display("FAIL coll_clear2: got %b expected 0000", irq_vec);
        end
        idle(14);
        bus_write(2, R_EN, 48'h1);
        checks++;
        if (irq_vec !== 4'b0100) begin
            errors++; $display("FAIL coll_en_pend: got %b expected 0100", irq_vec);
        end
        bus_read(2, R_CNT, d, dn);
        checks++;
        if (d !== 48'd3) begin
            errors++; $display("FAIL coll_en_load: got %0d expected 3", d);
        end
        bus_read(2, R_CNT, d, dn);
        checks++;
        if (d !== 48'd2) begin
            errors++; $display("FAIL coll_en_count: got %0d expected 2", d);
        end
        bus_write(2, R_EN, 48'h0);
        bus_write(2, R_STAT, 48'h1);
        checks++;
        if (irq_vec !== 4'b0000) begin
            errors++; $display("FAIL coll_stop: got %b expected 0000", irq_vec);
        end
    endtask

    task automatic test_isolation();
        logic [47:0] d;
        logic        dn;
        bus_write(1, R_MODE, 48'd1);
        bus_write(1, R_PRD, 48'd2);
        bus_write(1, R_IEN, 48'd1);
        bus_write(3, R_MODE, 48'd1);
        bus_write(3, R_PRD, 48'd4);
        bus_write(3, R_IEN, 48'd0);
        bus_write(1, R_EN, 48'd1);
        bus_write(3, R_EN, 48'd1);
        bus_read(1, R_CNT, d, dn);
        checks++;
        if (d !== 48'd1) begin
            errors++; $display("FAIL iso_cnt1: got %0d expected 1", d);
        end
        bus_read(3, R_CNT, d, dn);
        checks++;
        if (d !== 48'd3) begin
            errors++; $display("FAIL iso_cnt3: got %0d expected 3", d);
        end
        idle(4);
        checks++;
        if (irq_vec !== 4'b0010 || interrupt !== 1'b1) begin
            errors++; $display("FAIL iso_vec: got %b/%0b expected 0010/1", irq_vec, interrupt);
        end
        bus_read(3, R_STAT, d, dn);
        checks++;
        if (d !== 48'h3) begin
            errors++; $display("FAIL iso_stat3: got %0h expected 3", d);
        end
        bus_read(1, R_STAT, d, dn);
        checks++;
        if (d !== 48'h3) begin
            errors++; $display("FAIL iso_stat1: got %0h expected 3", d);
        end
        bus_write(1, R_EN, 48'h0);
        bus_write(3, R_EN, 48'h0);
        bus_write(1, R_STAT, 48'h1);
        bus_write(3, R_STAT, 48'h1);
        checks++;
        if (irq_vec !== 4'b0000) begin
            errors++; $display("FAIL iso_stop: got %b expected 0000", irq_vec);
        end
    endtask

    task automatic test_bus();
        logic [47:0] d;
        logic        dn;
        bus_read(0, R_PRD, d, dn);
        checks++;
        if (d !== 48'd5 || dn !== 1'b1) begin
            errors++; $display("FAIL bus_prd0: got %0h/%0b expected 5/1", d, dn);
        end
        bus_read(6, R_PRD, d, dn);
        checks++;
        if (d !== 48'h0 || dn !== 1'b1) begin
            errors++; $display("FAIL bus_unmapped: got %0h/%0b expected 0/1", d, dn);
        end
        idle(1);
        checks++;
        if (tim_done !== 1'b0) begin
            errors++; $display("FAIL bus_done_idle: got %0b expected 0", tim_done);
        end
        bus_write(0, R_CNT, 48'd99);
        checks++;
        if (tim_done !== 1'b1) begin
            errors++; $display("FAIL bus_wr_done: got %0b expected 1", tim_done);
        end
        bus_read(0, R_CNT, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL bus_cnt_ro: got %0h expected 0", d);
        end
        bus_write(0, R_RSVD, 48'hFFFF_FFFF_FFFF);
        bus_read(0, R_RSVD, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL bus_rsvd: got %0h expected 0", d);
        end
        bus_write(4, R_PRD, 48'd77);
        bus_read(0, R_PRD, d, dn);
        checks++;
        if (d !== 48'd5) begin
            errors++; $display("FAIL bus_alias: got %0h expected 5", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] d;
        logic        dn;
        bus_read(0, R_PRD, d, dn);
        checks++;
        if (d !== 48'd5 || dn !== 1'b1) begin
            errors++; $display("FAIL b2b_0: got %0h/%0b expected 5/1", d, dn);
        end
        bus_read(2, R_PRD, d, dn);
        checks++;
        if (d !== 48'd3 || dn !== 1'b1) begin
            errors++; $display("FAIL b2b_1: got %0h/%0b expected 3/1", d, dn);
        end
        bus_read(1, R_PRD, d, dn);
        checks++;
        if (d !== 48'd2 || dn !== 1'b1) begin
            errors++; $display("FAIL b2b_2: got %0h/%0b expected 2/1", d, dn);
        end
        idle(1);
        checks++;
        if (tim_done !== 1'b0 || tim_rdata !== 48'd2) begin
            errors++; $display("FAIL b2b_end: got %0b/%0h expected 0/2", tim_done, tim_rdata);
        end
    endtask

    task automatic test_reset_midcount();
        logic [47:0] d;
        logic        dn;
        bus_write(1, R_PRD, 48'd0);
        bus_write(1, R_EN, 48'd1);
        bus_write(1, R_PRD, 48'd20);
        bus_write(1, R_EN, 48'd1);
        idle(3);
        bus_read(1, R_CNT, d, dn);
        checks++;
        if (d !== 48'd17) begin
            errors++; $display("FAIL mid_cnt: got %0d expected 17", d);
        end
        checks++;
        if (irq_vec !== 4'b0010) begin
            errors++; $display("FAIL mid_pend: got %b expected 0010", irq_vec);
        end
        tim_addr = 15'((1 << 3) | R_CNT);
        tim_read = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        tim_read = 1'b0;
        reset    = 1'b0;
        $display("reset with pending read");
        checks++;
        if (tim_done !== 1'b0 || tim_rdata !== 48'h0) begin
            errors++; $display("FAIL mid_bus: got %0b/%0h expected 0/0", tim_done, tim_rdata);
        end
        checks++;
        if (interrupt !== 1'b0 || irq_vec !== 4'b0000) begin
            errors++; $display("FAIL mid_irq: got %0b/%b expected 0/0000", interrupt, irq_vec);
        end
        bus_read(1, R_CNT, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL mid_cnt_rst: got %0h expected 0", d);
        end
        bus_read(1, R_STAT, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL mid_stat_rst: got %0h expected 0", d);
        end
        bus_read(1, R_MODE, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL mid_mode_rst: got %0h expected 0", d);
        end
        bus_read(0, R_PRD, d, dn);
        checks++;
        if (d !== 48'h0) begin
            errors++; $display("FAIL mid_prd_rst: got %0h expected 0", d);
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_collision();
        test_isolation();
        test_bus();
        test_back_to_back();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
